// File: rtl/cache_def.sv
// Shared cache/memory definitions: backing-memory FSM states and default sizing.
// Contents: mem_state_t (IDLE, WAIT, RESP), MEM_* default parameter values.
// Imported by lat_line_memory and line_mem_array.
package cache_def;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int MEM_DATA_W  = 128;
    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_DEPTH   = 1024;
    localparam int MEM_LATENCY = 1;

endpackage

// File: rtl/line_mem_array.sv
// Line storage for lat_line_memory: DEPTH x DATA_W, zero at power-up, no reset.
// Ports: i_clk, i_wr_en/i_idx/i_wr_data (write on rising edge), o_rd_data (line at i_idx).
// The read is asynchronous; the parent samples it on the accept edge.
module line_mem_array
    import cache_def::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = MEM_DEPTH,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    // Deliberately outside any reset so contents survive rst_i.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_idx];

endmodule

// File: rtl/lat_line_memory.sv
// Line-granular backing memory with configurable accept-to-response latency.
// Ports: req_* valid/ready request (rw, byte addr, write line), resp_* one-cycle
// response strobe with registered data, stat_rd_o/stat_wr_o counters (MEM_STATS_EN).
module lat_line_memory
    import cache_def::*;
#(
    parameter int DATA_W  = MEM_DATA_W,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DEPTH   = MEM_DEPTH,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_rw_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              req_ready_o,
    output logic              resp_valid_o,
    output logic              resp_write_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [31:0]       stat_rd_o,
    output logic [31:0]       stat_wr_o
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // WAIT counts down from LATENCY-2 to 0, so it needs to hold LATENCY-2.
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ready;
    logic              w_accept;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic              r_resp_write;
    logic [DATA_W-1:0] r_resp_data;
    logic              w_unused_addr;

    // Offset bits select a byte within the line and upper bits alias.
    assign w_idx         = (DEPTH > 1) ? req_addr_i[OFF_W +: IDX_W] : '0;
    assign w_unused_addr = ^req_addr_i;

    assign w_ready  = (r_state != WAIT);
    // No accept while reset is held, so a request cannot sneak into the array.
    assign w_accept = req_valid_i & w_ready & ~rst_i;

    line_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .i_clk     (clk_i),
        .i_wr_en   (w_accept & req_rw_i),
        .i_idx     (w_idx),
        .i_wr_data (req_data_i),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response payload is captured on the accept edge and held until the next
    // accept; the read sees the array before any write on that same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp_write <= 1'b0;
            r_resp_data  <= '0;
        end else if (w_accept) begin
            r_resp_write <= req_rw_i;
            r_resp_data  <= req_rw_i ? req_data_i : w_rd_data;
        end
    end

    assign req_ready_o  = w_ready;
    assign resp_valid_o = (r_state == RESP);
    assign resp_write_o = r_resp_write;
    assign resp_data_o  = r_resp_data;

`ifdef MEM_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_wr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else if (w_accept) begin
            if (req_rw_i) begin
                if (r_stat_wr != 32'hFFFF_FFFF) r_stat_wr <= r_stat_wr + 32'd1;
            end else begin
                if (r_stat_rd != 32'hFFFF_FFFF) r_stat_rd <= r_stat_rd + 32'd1;
            end
        end
    end

    assign stat_rd_o = r_stat_rd;
    assign stat_wr_o = r_stat_wr;
`else
    assign stat_rd_o = 32'd0;
    assign stat_wr_o = 32'd0;
`endif

endmodule

// File: tb/tb_lat_line_memory.sv
// Bench for lat_line_memory: three instances (LATENCY 1, 2, 4; DEPTH 16, 128-bit lines)
// driven from directed tables, hand-written reset/stat sequences and random traffic,
// each cycle compared against a cycle-count reference model.
module tb_lat_line_memory;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         req_valid [N];
    logic         req_rw    [N];
    logic [31:0]  req_addr  [N];
    logic [127:0] req_data  [N];
    logic         req_ready [N];
    logic         resp_valid[N];
    logic         resp_write[N];
    logic [127:0] resp_data [N];
    logic [31:0]  stat_rd   [N];
    logic [31:0]  stat_wr   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        lat_line_memory #(
            .DATA_W  (128),
            .ADDR_W  (32),
            .DEPTH   (16),
            .LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req_valid_i  (req_valid[g]),
            .req_rw_i     (req_rw[g]),
            .req_addr_i   (req_addr[g]),
            .req_data_i   (req_data[g]),
            .req_ready_o  (req_ready[g]),
            .resp_valid_o (resp_valid[g]),
            .resp_write_o (resp_write[g]),
            .resp_data_o  (resp_data[g]),
            .stat_rd_o    (stat_rd[g]),
            .stat_wr_o    (stat_wr[g])
        );
    end

    typedef struct {
        int           g;
        bit           v;
        bit           rw;
        logic [31:0]  a;
        logic [127:0] d;
        bit           er;
        bit           ev;
        bit           ew;
        logic [127:0] ed;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle arithmetic only. An accept in cycle t answers in
    // cycle t+L and the instance is ready again from cycle t+L.
    int           lat [N] = '{1, 2, 4};
    int           cyc;
    int           nxt_rdy [N];
    int           resp_cyc[N];
    logic [127:0] m_mem   [N][16];
    logic [127:0] m_data  [N];
    bit           m_wr    [N];
    logic [31:0]  m_srd   [N];
    logic [31:0]  m_swr   [N];

    task automatic chk(input string nm, input int g, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d got %h want %h", nm, g, cyc, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int g = 0; g < N; g++) begin
            req_valid[g] = 1'b0;
            req_rw[g]    = 1'b0;
            req_addr[g]  = '0;
            req_data[g]  = '0;
        end
    endtask

    task automatic step(input bit use_v, input vec_t v);
        int idx;
        @(negedge clk);
        if (rst) begin
            for (int g = 0; g < N; g++) begin
                nxt_rdy[g]  = cyc;
                resp_cyc[g] = -1;
                m_data[g]   = '0;
                m_wr[g]     = 1'b0;
                m_srd[g]    = '0;
                m_swr[g]    = '0;
            end
        end
        for (int g = 0; g < N; g++) begin
            chk("ready",  g, req_ready[g],  cyc >= nxt_rdy[g]);
            chk("rvalid", g, resp_valid[g], cyc == resp_cyc[g]);
            chk("rwrite", g, resp_write[g], m_wr[g]);
            chk("rdata",  g, resp_data[g],  m_data[g]);
            chk("stat_rd", g, stat_rd[g], m_srd[g]);
            chk("stat_wr", g, stat_wr[g], m_swr[g]);
        end
        if (use_v) begin
            chk("tab_ready",  v.g, req_ready[v.g],  v.er);
            chk("tab_rvalid", v.g, resp_valid[v.g], v.ev);
            chk("tab_rwrite", v.g, resp_write[v.g], v.ew);
            chk("tab_rdata",  v.g, resp_data[v.g],  v.ed);
        end
        if (!rst) begin
            for (int g = 0; g < N; g++) begin
                if (req_valid[g] && cyc >= nxt_rdy[g]) begin
                    idx = int'((req_addr[g] / 16) % 16);
                    if (req_rw[g]) begin
                        m_mem[g][idx] = req_data[g];
                        m_data[g]     = req_data[g];
`ifdef MEM_STATS_EN
                        if (m_swr[g] != 32'hFFFF_FFFF) m_swr[g]++;
`endif
                    end else begin
                        m_data[g] = m_mem[g][idx];
`ifdef MEM_STATS_EN
                        if (m_srd[g] != 32'hFFFF_FFFF) m_srd[g]++;
`endif
                    end
                    m_wr[g]     = req_rw[g];
                    resp_cyc[g] = cyc + lat[g];
                    nxt_rdy[g]  = cyc + lat[g];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic vec_t mk(int g, bit v, bit rw, logic [31:0] a, logic [127:0] d,
                                bit er, bit ev, bit ew, logic [127:0] ed);
        vec_t r;
        r.g = g; r.v = v; r.rw = rw; r.a = a; r.d = d;
        r.er = er; r.ev = ev; r.ew = ew; r.ed = ed;
        return r;
    endfunction

    task automatic drive_one(input int g, input bit v, input bit rw, input logic [31:0] a,
                             input logic [127:0] d);
        idle_all();
        req_valid[g] = v;
        req_rw[g]    = rw;
        req_addr[g]  = a;
        req_data[g]  = d;
    endtask

    vec_t         tab[$];
    vec_t         nov;
    logic [127:0] a5;
    logic [31:0]  exp_rd;
    logic [31:0]  exp_wr;

    initial begin
        a5  = {16{8'hA5}};
        cyc = 0;
        nov = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int g = 0; g < N; g++) begin
            nxt_rdy[g] = 0; resp_cyc[g] = -1;
            m_data[g] = '0; m_wr[g] = 0; m_srd[g] = '0; m_swr[g] = '0;
            for (int i = 0; i < 16; i++) m_mem[g][i] = '0;
        end
        idle_all();
        rst = 1'b1;
        step(0, nov);
        step(0, nov);
        rst = 1'b0;
        step(0, nov);

        // g, v, rw, addr, data | ready, rvalid, rwrite, rdata (sampled that cycle)
        // LATENCY=1: write then read 0x40 back to back.
        tab.push_back(mk(0, 1, 1, 32'h40, a5,  1, 0, 0, 0));
        tab.push_back(mk(0, 1, 0, 32'h40, 0,   1, 1, 1, a5));
        tab.push_back(mk(0, 0, 0, 0,      0,   1, 1, 0, a5));
        tab.push_back(mk(0, 0, 0, 0,      0,   1, 0, 0, a5));
        // Aliasing, DEPTH=16: 0x000, 0x100 and 0x004 share line 0.
        tab.push_back(mk(0, 1, 1, 32'h000, 128'h1, 1, 0, 0, a5));
        tab.push_back(mk(0, 1, 0, 32'h100, 0,      1, 1, 1, 128'h1));
        tab.push_back(mk(0, 1, 0, 32'h004, 0,      1, 1, 0, 128'h1));
        tab.push_back(mk(0, 0, 0, 0,       0,      1, 1, 0, 128'h1));
        tab.push_back(mk(0, 0, 0, 0,       0,      1, 0, 0, 128'h1));
        // LATENCY=4: read 0x100; a held write is ignored until RESP.
        tab.push_back(mk(2, 1, 0, 32'h100, 0,       1, 0, 0, 0));
        tab.push_back(mk(2, 1, 1, 32'h200, 128'h77, 0, 0, 0, 0));
        tab.push_back(mk(2, 1, 1, 32'h200, 128'h77, 0, 0, 0, 0));
        tab.push_back(mk(2, 1, 1, 32'h200, 128'h77, 0, 0, 0, 0));
        tab.push_back(mk(2, 1, 1, 32'h200, 128'h77, 1, 1, 0, 0));
        tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 128'h77));
        tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 128'h77));
        tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 128'h77));
        tab.push_back(mk(2, 0, 0, 0, 0, 1, 1, 1, 128'h77));
        tab.push_back(mk(2, 0, 0, 0, 0, 1, 0, 1, 128'h77));
        // LATENCY=2 back to back: accepts every 2nd cycle, own data per response.
        tab.push_back(mk(1, 1, 1, 32'h10, 128'h11, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 1, 32'h20, 128'h22, 0, 0, 1, 128'h11));
        tab.push_back(mk(1, 1, 1, 32'h20, 128'h22, 1, 1, 1, 128'h11));
        tab.push_back(mk(1, 1, 0, 32'h10, 0,       0, 0, 1, 128'h22));
        tab.push_back(mk(1, 1, 0, 32'h10, 0,       1, 1, 1, 128'h22));
        tab.push_back(mk(1, 0, 0, 0,      0,       0, 0, 0, 128'h11));
        tab.push_back(mk(1, 0, 0, 0,      0,       1, 1, 0, 128'h11));
        tab.push_back(mk(1, 0, 0, 0,      0,       1, 0, 0, 128'h11));

        foreach (tab[i]) begin
            drive_one(tab[i].g, tab[i].v, tab[i].rw, tab[i].a, tab[i].d);
            step(1, tab[i]);
        end
        idle_all();
        step(0, nov);

        // Reset two cycles into a LATENCY=4 write: response dropped, write kept.
        drive_one(2, 1, 1, 32'h80, 128'hBEEF);
        step(0, nov);
        idle_all();
        step(0, nov);
        step(0, nov);
        rst = 1'b1;
        step(0, nov);
        chk("rst_ready",  2, req_ready[2],  1);
        chk("rst_rvalid", 2, resp_valid[2], 0);
        chk("rst_rwrite", 2, resp_write[2], 0);
        chk("rst_rdata",  2, resp_data[2],  0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, nov);
            chk("rst_no_pulse", 2, resp_valid[2], 0);
        end
        drive_one(2, 1, 0, 32'h80, 0);
        step(0, nov);
        idle_all();
        for (int i = 0; i < 3; i++) step(0, nov);
        chk("rst_keep_valid", 2, resp_valid[2], 1);
        chk("rst_keep_data",  2, resp_data[2],  128'hBEEF);
        step(0, nov);

        // Statistics: 3 reads + 2 writes on the LATENCY=1 instance.
        rst = 1'b1;
        step(0, nov);
        rst = 1'b0;
        drive_one(0, 1, 0, 32'h00, 0);          step(0, nov);
        drive_one(0, 1, 1, 32'h30, 128'h5);     step(0, nov);
        drive_one(0, 1, 0, 32'h30, 0);          step(0, nov);
        drive_one(0, 1, 1, 32'h40, 128'h6);     step(0, nov);
        drive_one(0, 1, 0, 32'h40, 0);          step(0, nov);
        idle_all();
        step(0, nov);
`ifdef MEM_STATS_EN
        exp_rd = 32'd3;
        exp_wr = 32'd2;
`else
        exp_rd = 32'd0;
        exp_wr = 32'd0;
`endif
        chk("stat_rd_count", 0, stat_rd[0], exp_rd);
        chk("stat_wr_count", 0, stat_wr[0], exp_wr);
        rst = 1'b1;
        step(0, nov);
        chk("stat_rd_clear", 0, stat_rd[0], 0);
        chk("stat_wr_clear", 0, stat_wr[0], 0);
        rst = 1'b0;

        // Random traffic on all instances, with the odd reset.
        for (int n = 0; n < 800; n++) begin
            for (int g = 0; g < N; g++) begin
                req_valid[g] = ($urandom_range(0, 9) < 7);
                req_rw[g]    = $urandom_range(0, 1) == 1;
                req_addr[g]  = $urandom;
                req_data[g]  = {$urandom, $urandom, $urandom, $urandom};
            end
            rst = ($urandom_range(0, 149) == 0);
            step(0, nov);
        end
        rst = 1'b0;
        idle_all();
        step(0, nov);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
